// File: rtl/dcache_ctrl.sv
// Single-port line data cache sequencer: lookup, miss fill, clean install and dirty-victim writeback.
// Define DCACHE_CTRL_PERF_EN to add hit/miss/writeback counters (perf_*_o ports).
module dcache_ctrl #(
    parameter int addr_width = 16,
    parameter int line_width = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [addr_width-1:0] req_addr_i,
    input  logic [line_width-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic [line_width-1:0] resp_data_o,
    output logic [addr_width-1:0] cache_addr_o,
    output logic                  cache_r_valid_o,
    output logic                  cache_w_valid_o,
    output logic                  cache_dirty_o,
    output logic [line_width-1:0] cache_wdata_o,
    input  logic                  cache_r_valid_i,
    input  logic                  cache_r_miss_i,
    input  logic [line_width-1:0] cache_rdata_i,
    input  logic                  cache_ej_valid_i,
    input  logic [addr_width-1:0] cache_ej_addr_i,
    input  logic [line_width-1:0] cache_ej_data_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_we_o,
    output logic [addr_width-1:0] mem_addr_o,
    output logic [line_width-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [line_width-1:0] mem_rdata_i
`ifdef DCACHE_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_hits_o,
    output logic [31:0]           perf_misses_o,
    output logic [31:0]           perf_wbs_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_FILL_REQ, S_FILL_WAIT, S_INSTALL, S_EJECT, S_WB_REQ, S_RESP
    } state_t;

    state_t                r_state;
    logic [addr_width-1:0] r_addr;
    logic [addr_width-1:0] r_wb_addr;
    logic [line_width-1:0] r_wb_data;
    logic [line_width-1:0] r_fill;
    logic [line_width-1:0] r_resp;
    logic                  w_accept;
    logic                  w_accept_wr;
    logic                  w_hit;

    assign req_ready_o = rst_ni && (r_state == S_IDLE);
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_accept_wr = w_accept && req_we_i;
    assign w_hit       = cache_r_valid_i && !cache_r_miss_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_fill    <= '0;
            r_resp    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= req_addr_i;
                        r_state <= req_we_i ? S_EJECT : S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_resp  <= cache_rdata_i;
                        r_state <= S_RESP;
                    end else begin
                        r_state <= S_FILL_REQ;
                    end
                end
                S_FILL_REQ: begin
                    if (mem_req_ready_i) r_state <= S_FILL_WAIT;
                end
                S_FILL_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_fill  <= mem_rdata_i;
                        r_resp  <= mem_rdata_i;
                        r_state <= S_INSTALL;
                    end
                end
                S_INSTALL: r_state <= S_EJECT;
                // The cache reports a dirty victim one cycle after any write strobe
                S_EJECT: begin
                    if (cache_ej_valid_i) begin
                        r_wb_addr <= cache_ej_addr_i;
                        r_wb_data <= cache_ej_data_i;
                        r_state   <= S_WB_REQ;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                S_WB_REQ: begin
                    if (mem_req_ready_i) r_state <= S_RESP;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cache_r_valid_o = w_accept && !req_we_i;
    assign cache_w_valid_o = w_accept_wr || (r_state == S_INSTALL);
    assign cache_dirty_o   = w_accept_wr;
    assign cache_addr_o    = w_accept ? req_addr_i :
                             (r_state == S_INSTALL) ? r_addr : '0;
    assign cache_wdata_o   = w_accept_wr ? req_wdata_i :
                             (r_state == S_INSTALL) ? r_fill : '0;

    assign mem_req_valid_o = (r_state == S_FILL_REQ) || (r_state == S_WB_REQ);
    assign mem_we_o        = (r_state == S_WB_REQ);
    assign mem_addr_o      = (r_state == S_WB_REQ) ? r_wb_addr :
                             (r_state == S_FILL_REQ) ? r_addr : '0;
    assign mem_wdata_o     = (r_state == S_WB_REQ) ? r_wb_data : '0;

    assign resp_valid_o    = (r_state == S_RESP);
    assign resp_data_o     = r_resp;

`ifdef DCACHE_CTRL_PERF_EN
    logic [31:0] r_hits;
    logic [31:0] r_misses;
    logic [31:0] r_wbs;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hits   <= '0;
            r_misses <= '0;
            r_wbs    <= '0;
        end else begin
            if (r_state == S_LOOKUP) begin
                if (w_hit) r_hits   <= r_hits + 32'd1;
                else       r_misses <= r_misses + 32'd1;
            end
            if ((r_state == S_WB_REQ) && mem_req_ready_i) r_wbs <= r_wbs + 32'd1;
        end
    end

    assign perf_hits_o   = r_hits;
    assign perf_misses_o = r_misses;
    assign perf_wbs_o    = r_wbs;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl with a behavioural cache (depth 64), memory and data reference model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [15:0] req_addr_i = '0;
    logic [63:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic [63:0] resp_data_o;
    logic [15:0] cache_addr_o;
    logic        cache_r_valid_o;
    logic        cache_w_valid_o;
    logic        cache_dirty_o;
    logic [63:0] cache_wdata_o;
    logic        cache_r_valid_i = 1'b0;
    logic        cache_r_miss_i = 1'b0;
    logic [63:0] cache_rdata_i = '0;
    logic        cache_ej_valid_i = 1'b0;
    logic [15:0] cache_ej_addr_i = '0;
    logic [63:0] cache_ej_data_i = '0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
`ifdef DCACHE_CTRL_PERF_EN
    logic [31:0] perf_hits_o, perf_misses_o, perf_wbs_o;
`endif

    always #5 clk = ~clk;

    dcache_ctrl #(.addr_width(16), .line_width(64)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
        .cache_addr_o(cache_addr_o), .cache_r_valid_o(cache_r_valid_o),
        .cache_w_valid_o(cache_w_valid_o), .cache_dirty_o(cache_dirty_o),
        .cache_wdata_o(cache_wdata_o), .cache_r_valid_i(cache_r_valid_i),
        .cache_r_miss_i(cache_r_miss_i), .cache_rdata_i(cache_rdata_i),
        .cache_ej_valid_i(cache_ej_valid_i), .cache_ej_addr_i(cache_ej_addr_i),
        .cache_ej_data_i(cache_ej_data_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef DCACHE_CTRL_PERF_EN
        , .perf_hits_o(perf_hits_o), .perf_misses_o(perf_misses_o), .perf_wbs_o(perf_wbs_o)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] init_line(input logic [15:0] a);
        return {32'hDEADBEEF, 16'h0000, a};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural cache: direct mapped, 64 sets ----------------
    logic        c_valid [0:63] = '{default: 1'b0};
    logic        c_dirty [0:63] = '{default: 1'b0};
    logic [15:0] c_tag   [0:63] = '{default: 16'h0};
    logic [63:0] c_data  [0:63] = '{default: 64'h0};
    logic [5:0]  c_set;
    assign c_set = cache_addr_o[5:0];

    always @(posedge clk) begin
        cache_r_valid_i  <= 1'b0;
        cache_ej_valid_i <= 1'b0;
        if (cache_r_valid_o) begin
            cache_r_valid_i <= 1'b1;
            cache_r_miss_i  <= !(c_valid[c_set] && (c_tag[c_set] == cache_addr_o));
            cache_rdata_i   <= c_data[c_set];
        end
        if (cache_w_valid_o) begin
            if (c_valid[c_set] && c_dirty[c_set] && (c_tag[c_set] != cache_addr_o)) begin
                cache_ej_valid_i <= 1'b1;
                cache_ej_addr_i  <= c_tag[c_set];
                cache_ej_data_i  <= c_data[c_set];
            end
            c_valid[c_set] <= 1'b1;
            c_dirty[c_set] <= cache_dirty_o;
            c_tag[c_set]   <= cache_addr_o;
            c_data[c_set]  <= cache_wdata_o;
        end
    end

    // ---------------- backing memory ----------------
    logic [63:0] mem   [0:65535];
    logic        mem_w [0:65535] = '{default: 1'b0};
    logic        hold_low = 1'b0;
    int          fill_lat = 3;
    logic        fill_pending = 1'b0;
    int          fill_cnt = 0;
    logic [15:0] fill_addr = '0;
    int          n_fill = 0, n_wb = 0, last_wb_cyc = 0, n_mreq_cyc = 0;
    logic [15:0] last_fill_addr = '0, last_wb_addr = '0;
    logic [63:0] last_wb_data = '0;

    function automatic logic [63:0] mem_rd(input logic [15:0] a);
        return mem_w[a] ? mem[a] : init_line(a);
    endfunction

    always @(negedge clk) mem_req_ready_i = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);

    always @(posedge clk) begin
        mem_rvalid_i <= 1'b0;
        if (mem_req_valid_o) n_mreq_cyc <= n_mreq_cyc + 1;
        if (fill_pending) begin
            if (fill_cnt <= 1) begin
                mem_rvalid_i <= 1'b1;
                mem_rdata_i  <= mem_rd(fill_addr);
                fill_pending <= 1'b0;
            end else begin
                fill_cnt <= fill_cnt - 1;
            end
        end
        if (mem_req_valid_o && mem_req_ready_i) begin
            if (mem_we_o) begin
                mem[mem_addr_o]   <= mem_wdata_o;
                mem_w[mem_addr_o] <= 1'b1;
                n_wb              <= n_wb + 1;
                last_wb_addr      <= mem_addr_o;
                last_wb_data      <= mem_wdata_o;
                last_wb_cyc       <= cyc;
            end else begin
                fill_pending   <= 1'b1;
                fill_cnt       <= fill_lat;
                fill_addr      <= mem_addr_o;
                n_fill         <= n_fill + 1;
                last_fill_addr <= mem_addr_o;
            end
        end
    end

    // Memory request must hold steady while stalled
    logic        st_wait = 1'b0;
    logic [17:0] st_ctl = '0;
    logic [63:0] st_data = '0;
    always @(posedge clk) begin
        if (rst_ni && st_wait) begin
            chk("mem_req_stable_ctl", 64'({mem_req_valid_o, mem_we_o, mem_addr_o}), 64'(st_ctl));
            chk("mem_req_stable_wdata", mem_wdata_o, st_data);
        end
        st_wait <= rst_ni && mem_req_valid_o && !mem_req_ready_i;
        st_ctl  <= {mem_req_valid_o, mem_we_o, mem_addr_o};
        st_data <= mem_wdata_o;
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;
    exp_t        sb[$];
    exp_t        sb_e;
    logic [63:0] ref_data [logic [15:0]];
    logic [63:0] ref_last = '0;
    int          last_resp_cyc = 0;

    function automatic logic [63:0] ref_rd(input logic [15:0] a);
        return ref_data.exists(a) ? ref_data[a] : init_line(a);
    endfunction

    always @(negedge clk) begin
        if (rst_ni) begin
            if (cache_r_valid_o || cache_w_valid_o)
                chk("strobe_mutex", 64'(cache_r_valid_o && cache_w_valid_o), 64'd0);
            if (resp_valid_o) begin
                last_resp_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    sb_e = sb.pop_front();
                    chk("resp_data", resp_data_o, sb_e.data);
                    if (sb_e.due >= 0) chk("resp_latency", 64'(cyc), 64'(sb_e.due));
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [15:0] a, input logic [63:0] d, input int lat);
        exp_t e;
        int   guard;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = d;
        guard = 0;
        while (!req_ready_o && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready_o) begin
            chk("req_accept_timeout", 64'd0, 64'd1);
            req_valid_i = 1'b0;
            return;
        end
        e.data = we ? ref_last : ref_rd(a);
        e.due  = (lat < 0) ? -1 : cyc + lat;
        if (we) ref_data[a] = d;
        else    ref_last    = ref_rd(a);
        sb.push_back(e);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((sb.size() != 0 || !req_ready_o) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0 || !req_ready_o) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, 64'({req_ready_o, resp_valid_o, cache_r_valid_o, cache_w_valid_o,
                                cache_dirty_o, mem_req_valid_o, mem_we_o}), 64'd0);
        chk({tag, "_resp_data"}, resp_data_o, 64'd0);
        chk({tag, "_addrs"}, 64'({cache_addr_o, mem_addr_o}), 64'd0);
        chk({tag, "_cache_wdata"}, cache_wdata_o, 64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nf, nw, nm, viol, seen;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_ni = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(req_ready_o), 64'd1);

        // 1: cold read, fill from memory
        nf = n_fill; nw = n_wb;
        do_req(1'b0, 16'h0045, 64'h0, -1);
        wait_idle();
        chk("t1_fill_count", 64'(n_fill - nf), 64'd1);
        chk("t1_fill_addr", 64'(last_fill_addr), 64'h0045);
        chk("t1_no_wb", 64'(n_wb - nw), 64'd0);
        chk("t1_resp_data", resp_data_o, 64'hDEADBEEF00000045);

        // 2: reread hits, no memory traffic
        nm = n_mreq_cyc;
        do_req(1'b0, 16'h0045, 64'h0, 2);
        wait_idle();
        chk("t2_no_mem_req", 64'(n_mreq_cyc - nm), 64'd0);
        chk("t2_resp_data", resp_data_o, 64'hDEADBEEF00000045);

        // 3: write over a clean victim
        nm = n_mreq_cyc;
        do_req(1'b1, 16'h0085, 64'h1111, 2);
        wait_idle();
        chk("t3_no_mem_req", 64'(n_mreq_cyc - nm), 64'd0);

        // 4: read miss evicting the dirty line
        nf = n_fill; nw = n_wb;
        do_req(1'b0, 16'h00C5, 64'h0, -1);
        wait_idle();
        chk("t4_fill_addr", 64'(last_fill_addr), 64'h00C5);
        chk("t4_wb_count", 64'(n_wb - nw), 64'd1);
        chk("t4_wb_addr", 64'(last_wb_addr), 64'h0085);
        chk("t4_wb_data", last_wb_data, 64'h1111);
        chk("t4_wb_before_resp", 64'(last_wb_cyc < last_resp_cyc), 64'd1);
        chk("t4_resp_data", resp_data_o, 64'hDEADBEEF000000C5);
`ifdef DCACHE_CTRL_PERF_EN
        chk("t4_perf_wbs", 64'(perf_wbs_o), 64'd1);
        chk("t4_perf_misses", 64'(perf_misses_o), 64'd2);
        chk("t4_perf_hits", 64'(perf_hits_o), 64'd1);
`endif

        // 5: memory stalls fill request for 5 cycles
        @(negedge clk);
        hold_low = 1'b1;
        nf = n_fill;
        do_req(1'b0, 16'h0107, 64'h0, -1);
        seen = 0;
        while (!mem_req_valid_o && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("t5_mem_valid_held", 64'(mem_req_valid_o), 64'd1);
            chk("t5_mem_addr_stable", 64'(mem_addr_o), 64'h0107);
            chk("t5_req_ready_low", 64'(req_ready_o), 64'd0);
            @(negedge clk);
        end
        hold_low = 1'b0;
        wait_idle();
        chk("t5_fill_count", 64'(n_fill - nf), 64'd1);

        // 6: reset during FILL_WAIT, late fill data must be ignored
        fill_lat = 8;
        do_req(1'b0, 16'h0209, 64'h0, -1);
        seen = 0;
        while (!fill_pending && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        chk("t6_reached_fill_wait", 64'(fill_pending), 64'd1);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk_outputs_zero("t6_reset");
        sb.delete();
        ref_last = '0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        viol = 0; seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (cache_w_valid_o || mem_req_valid_o || !req_ready_o) viol++;
            if (mem_rvalid_i) seen = 1;
        end
        chk("t6_late_rvalid_seen", 64'(seen), 64'd1);
        chk("t6_no_install", 64'(viol), 64'd0);
        chk("t6_ready", 64'(req_ready_o), 64'd1);
        chk("t6_resp_cleared", resp_data_o, 64'd0);

        // random traffic over a few conflicting tags in 8 sets
        for (int i = 0; i < 200; i++) begin
            logic        we;
            logic [15:0] a;
            fill_lat = $urandom_range(1, 4);
            we = ($urandom_range(0, 2) == 0);
            a  = 16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
            do_req(we, a, {$urandom, $urandom}, -1);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
